// File: rtl/rot_arb.sv
// rot_arb -- two-requester arbiter in front of a 4-bit rotate-right unit.
//
// A winning request has its operand and rotate amount captured on the grant edge. The result
// is presented LAT edges later and held until the consumer accepts it.
//
// Configuration macro:
//   RR_ARB_EN  defined   : round-robin arbitration on simultaneous requests
//              undefined : fixed priority, requester 0 wins
//
// Parameters:
//   LAT        rotate latency in cycles from capture to result (1..4)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req[1:0]   per-requester request, held until the matching gnt bit is seen
//   a0, a1     4-bit operand of requester 0 / 1
//   s0, s1     2-bit rotate amount of requester 0 / 1
//   gnt[1:0]   one-hot grant pulse, one cycle wide
//   busy       high whenever an operation is in flight or a result is pending
//   rsp_valid  result available
//   rsp_ready  consumer accepts result
//   rsp_id     requester that owns the result
//   rsp_data   rotated result
module rot_arb #(
  parameter int unsigned LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [3:0] a0,
  input  logic [3:0] a1,
  input  logic [1:0] s0,
  input  logic [1:0] s1,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_data
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [1:0] CntInit = 2'(LAT - 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] gnt_q, gnt_d;
  logic       id_q, id_d;
  logic [3:0] data_q, data_d;
  logic       win;

  function automatic logic [3:0] rotr(input logic [3:0] v, input logic [1:0] s);
    logic [7:0] dbl;
    dbl = {v, v} >> s;
    return dbl[3:0];
  endfunction

`ifdef RR_ARB_EN
  // Index of the requester granted most recently; resets to 1 so requester 0 goes first.
  logic last_q, last_d;

  always_comb begin
    if (req == 2'b11) begin
      win = ~last_q;
    end else begin
      win = req[1];
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == StIdle && req != 2'b00) begin
      last_d = win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Requester 0 always has priority.
  always_comb begin
    win = ~req[0];
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = 2'b00;
    id_d    = id_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          gnt_d   = win ? 2'b10 : 2'b01;
          id_d    = win;
          // Only the result is kept, so later operand changes cannot leak into it.
          data_d  = win ? rotr(a1, s1) : rotr(a0, s0);
          cnt_d   = CntInit;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == 2'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StDone: begin
        // No bypass: the accepting edge never captures a new request.
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      gnt_q   <= 2'b00;
      id_q    <= 1'b0;
      data_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StDone);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;

endmodule

// File: tb/tb_rot_arb.sv
// Directed self-checking bench for rot_arb. Three instances (LAT = 1, 3, 4) share the clock and
// operand inputs; each has its own reset, request and ready. Inputs change on the falling edge
// and outputs are checked on the falling edge, after the rising edge has settled.
module tb_rot_arb;

  logic       clk;
  logic [3:0] a0, a1;
  logic [1:0] s0, s1;

  logic       rst_n1, rst_n3, rst_n4;
  logic [1:0] req1, req3, req4;
  logic       rdy1, rdy3, rdy4;

  logic [1:0] gnt1, gnt3, gnt4;
  logic       busy1, busy3, busy4;
  logic       vld1, vld3, vld4;
  logic       id1, id3, id4;
  logic [3:0] data1, data3, data4;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_order [4];

  rot_arb #(.LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n1), .req(req1), .a0(a0), .a1(a1), .s0(s0), .s1(s1),
    .gnt(gnt1), .busy(busy1), .rsp_valid(vld1), .rsp_ready(rdy1), .rsp_id(id1),
    .rsp_data(data1)
  );

  rot_arb #(.LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n3), .req(req3), .a0(a0), .a1(a1), .s0(s0), .s1(s1),
    .gnt(gnt3), .busy(busy3), .rsp_valid(vld3), .rsp_ready(rdy3), .rsp_id(id3),
    .rsp_data(data3)
  );

  rot_arb #(.LAT(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n4), .req(req4), .a0(a0), .a1(a1), .s0(s0), .s1(s1),
    .gnt(gnt4), .busy(busy4), .rsp_valid(vld4), .rsp_ready(rdy4), .rsp_id(id4),
    .rsp_data(data4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference rotate: bit i of the result is bit (i+s) mod 4 of the operand.
  function automatic logic [3:0] ref_rotr(input logic [3:0] v, input int s);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[(i + s) % 4];
    return r;
  endfunction

  initial begin
`ifdef RR_ARB_EN
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    rst_n1 = 1'b0; rst_n3 = 1'b0; rst_n4 = 1'b0;
    req1 = 2'b00; req3 = 2'b00; req4 = 2'b00;
    rdy1 = 1'b0; rdy3 = 1'b0; rdy4 = 1'b0;
    a0 = 4'd0; a1 = 4'd0; s0 = 2'd0; s1 = 2'd0;

    // Reset state
    #1;
    chk("rst_gnt",  {6'd0, gnt1}, 8'h00);
    chk("rst_busy", {7'd0, busy1}, 8'h00);
    chk("rst_vld",  {7'd0, vld1}, 8'h00);
    chk("rst_id",   {7'd0, id1}, 8'h00);
    chk("rst_data", {4'd0, data1}, 8'h00);
    tick();
    tick();
    rst_n1 = 1'b1; rst_n3 = 1'b1; rst_n4 = 1'b1;
    tick();
    chk("idle_noreq_gnt",  {6'd0, gnt1}, 8'h00);
    chk("idle_noreq_busy", {7'd0, busy1}, 8'h00);

    // Basic transaction, LAT=1: 1100 rotated right by 2 is 0011
    req1 = 2'b01; a0 = 4'b1100; s0 = 2'd2; rdy1 = 1'b1;
    tick();
    chk("basic_gnt",  {6'd0, gnt1}, 8'h01);
    chk("basic_busy", {7'd0, busy1}, 8'h01);
    chk("basic_vld0", {7'd0, vld1}, 8'h00);
    req1 = 2'b00;
    tick();
    chk("basic_gnt_drop", {6'd0, gnt1}, 8'h00);
    chk("basic_vld",  {7'd0, vld1}, 8'h01);
    chk("basic_data", {4'd0, data1}, 8'h03);
    chk("basic_id",   {7'd0, id1}, 8'h00);
    tick();
    chk("basic_vld_drop", {7'd0, vld1}, 8'h00);
    chk("basic_idle",     {7'd0, busy1}, 8'h00);

    // Exhaustive operand x amount sweep
    for (int v = 0; v < 16; v++) begin
      for (int s = 0; s < 4; s++) begin
        req1 = 2'b01; a0 = 4'(v); s0 = 2'(s);
        tick();
        req1 = 2'b00;
        tick();
        chk($sformatf("rot_%0h_%0d", v, s), {4'd0, data1}, {4'd0, ref_rotr(4'(v), s)});
        tick();
      end
    end

    // Both requesting, held for four transactions
    a0 = 4'b0001; s0 = 2'd0; a1 = 4'b1000; s1 = 2'd1;
    req1 = 2'b11;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("arb_gnt%0d", t), {6'd0, gnt1}, {6'd0, exp_order[t]});
      tick();
      chk($sformatf("arb_id%0d", t), {7'd0, id1}, {7'd0, exp_order[t][1]});
      chk($sformatf("arb_data%0d", t), {4'd0, data1},
          exp_order[t][1] ? 8'h04 : 8'h01);
      tick();
      chk($sformatf("arb_nobypass%0d", t), {7'd0, busy1}, 8'h00);
    end
    req1 = 2'b00;
    tick();

    // req change during BUSY ignored; new req in accepting cycle captured one edge later
    req1 = 2'b01; a0 = 4'b0011; s0 = 2'd0; a1 = 4'b0101; s1 = 2'd2;
    tick();
    chk("acc_gnt0", {6'd0, gnt1}, 8'h01);
    req1 = 2'b10;
    tick();
    chk("acc_vld",  {7'd0, vld1}, 8'h01);
    chk("acc_id0",  {7'd0, id1}, 8'h00);
    chk("acc_data0", {4'd0, data1}, 8'h03);
    tick();
    chk("acc_gnt_none", {6'd0, gnt1}, 8'h00);
    chk("acc_idle",     {7'd0, busy1}, 8'h00);
    tick();
    chk("acc_gnt1", {6'd0, gnt1}, 8'h02);
    chk("acc_busy", {7'd0, busy1}, 8'h01);
    req1 = 2'b00;
    tick();
    chk("acc_id1",   {7'd0, id1}, 8'h01);
    chk("acc_data1", {4'd0, data1}, 8'h05);
    tick();

    // LAT=4: latency, backpressure hold, operand changes after capture ignored
    req4 = 2'b01; a0 = 4'b1100; s0 = 2'd1; rdy4 = 1'b0;
    tick();
    chk("l4_gnt", {6'd0, gnt4}, 8'h01);
    req4 = 2'b00; a0 = 4'b0000; s0 = 2'd3;
    chk("l4_vld_e0", {7'd0, vld4}, 8'h00);
    for (int e = 1; e < 4; e++) begin
      tick();
      chk($sformatf("l4_vld_e%0d", e), {7'd0, vld4}, 8'h00);
    end
    tick();
    chk("l4_vld_e4", {7'd0, vld4}, 8'h01);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("l4_hold%0d", c), {2'd0, vld4, id4, data4}, {2'd0, 1'b1, 1'b0, 4'b0110});
    end
    rdy4 = 1'b1;
    tick();
    chk("l4_accept", {7'd0, vld4}, 8'h00);

    // LAT=3: reset during BUSY discards the operation
    req3 = 2'b10; a1 = 4'b1111; s1 = 2'd0; rdy3 = 1'b1;
    tick();
    chk("l3_gnt", {6'd0, gnt3}, 8'h02);
    req3 = 2'b00;
    tick();
    chk("l3_busy", {7'd0, busy3}, 8'h01);
    rst_n3 = 1'b0;
    #1;
    chk("l3_rst_outs", {gnt3, busy3, vld3, id3, data3 != 4'd0}, 6'd0);
    chk("l3_rst_data", {4'd0, data3}, 8'h00);
    tick();
    rst_n3 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("l3_novld%0d", c), {7'd0, vld3}, 8'h00);
    end
    req3 = 2'b01; a0 = 4'b1010; s0 = 2'd3;
    tick();
    req3 = 2'b00;
    tick();
    tick();
    chk("l3_vld_e2", {7'd0, vld3}, 8'h00);
    tick();
    chk("l3_vld_e3", {7'd0, vld3}, 8'h01);
    chk("l3_data",   {4'd0, data3}, 8'h05);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
